// File: rtl/paralelo_serial_2b_pkg.sv
// Shared constants and types for the 2-bit parallel-to-serial stage.
package ps2b_pkg;

  localparam int unsigned W = 2;
  localparam logic [W-1:0] IDLE_PAT_DEF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSB  = 2'd1,
    ST_LSB  = 2'd2
  } state_e;

endpackage

// File: rtl/paralelo_serial_2b_if.sv
// Word-in / bit-out bus between the mux stage, this block and its consumer.
interface paralelo_serial_2b_if;
  import ps2b_pkg::*;

  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic         data_out;
  logic         valid_out;
  logic         bit_idx;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, valid_out, bit_idx
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, valid_out, bit_idx
  );

endinterface

// File: rtl/paralelo_serial_2b_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head entry read combinationally.
module fifo_sync_2b
  import ps2b_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  // Next pointers and storage; push while full and pop while empty are dropped.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_d = rd_q + PW'(1);
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/paralelo_serial_2b.sv
// Buffers 2-bit words and serialises them MSB first; idle pattern when empty.
module paralelo_serial_2b
  import ps2b_pkg::*;
#(
  parameter int unsigned  DEPTH    = 4,
  parameter int unsigned  AW       = 2,
  parameter logic [W-1:0] IDLE_PAT = IDLE_PAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  paralelo_serial_2b_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] word_q, word_d;
  logic         ph_q, ph_d;
  logic         data_out_q, data_out_d;
  logic         valid_out_q, valid_out_d;
  logic         bit_idx_q, bit_idx_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic [W-1:0] fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;

  // Accept only when there is room; a pop in the same cycle never frees a slot early.
  assign bus.ready_out = ~fifo_full & ~reset;
  assign fifo_push     = bus.valid_in & bus.ready_out;

  fifo_sync_2b #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state and next registered outputs of the serialiser.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    ph_d        = ph_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    bit_idx_d   = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          word_d      = fifo_rdata;
          data_out_d  = fifo_rdata[1];
          valid_out_d = 1'b1;
          bit_idx_d   = 1'b1;
          state_d     = ST_MSB;
        end else begin
          data_out_d = ph_q ? IDLE_PAT[0] : IDLE_PAT[1];
          ph_d       = ~ph_q;
        end
      end
      ST_MSB: begin
        data_out_d  = word_q[0];
        valid_out_d = 1'b1;
        bit_idx_d   = 1'b0;
        state_d     = ST_LSB;
      end
      ST_LSB: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          word_d      = fifo_rdata;
          data_out_d  = fifo_rdata[1];
          valid_out_d = 1'b1;
          bit_idx_d   = 1'b1;
          state_d     = ST_MSB;
        end else begin
          // Entering idle: this cycle emits the phase-0 idle bit.
          data_out_d = IDLE_PAT[1];
          ph_d       = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        ph_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, held word, idle phase and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      ph_q        <= 1'b0;
      data_out_q  <= 1'b0;
      valid_out_q <= 1'b0;
      bit_idx_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      ph_q        <= ph_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      bit_idx_q   <= bit_idx_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.bit_idx   = bit_idx_q;

endmodule
